dmem_lsu: RTL and testbench

Load/store sequencer between the CPU memory-access stage and `dmem_ctrl`. It accepts one request at a time over a valid/ready handshake and checks the address window and alignment. It then drives `dmem_ctrl` with the timing that block needs: one read-capture cycle for loads, and two cycles of held `we` for the read-modify-write store. It returns a single-cycle response carrying load data or an error.

---
 rtl/dmem_lsu_if.sv | 36 +++
 rtl/dmem_lsu.sv | 112 +++++++++++
 tb/tb_dmem_lsu.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// CPU request/response and dmem_ctrl-side signals of the load/store sequencer.
// slave = the sequencer; master = the CPU plus the dmem_ctrl environment.
interface dmem_lsu_if #(
  parameter int DMEM_AW = 18
);
  // Handshake: a request transfers on a rising clk edge where req_valid and
  // req_ready are both 1. The requester keeps req_* stable while req_valid
  // is 1 and req_ready is 0. rsp_valid is a single-cycle strobe with no
  // backpressure.
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [2:0]         req_memop;
  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic               rsp_valid;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;
  logic [DMEM_AW-1:0] mem_addr;
  logic [31:0]        mem_datain;
  logic [2:0]         mem_memop;
  logic               mem_we;
  logic [31:0]        mem_dataout;

  modport slave (
    input  req_valid, req_we, req_memop, req_addr, req_wdata, mem_dataout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_datain, mem_memop, mem_we
  );

  modport master (
    output req_valid, req_we, req_memop, req_addr, req_wdata, mem_dataout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_datain, mem_memop, mem_we
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store sequencer in front of dmem_ctrl: window/alignment checks, load capture, RMW store.
// Optional macro DMEM_LSU_ALIGN_CHECK_EN rejects misaligned half/word requests.
module dmem_lsu #(
  parameter logic [31:0] DMEM_BASE = 32'h0000_0000,
  parameter int          DMEM_AW   = 18
) (
  input  logic       clk,
  input  logic       rst,
  dmem_lsu_if.slave  bus,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_CAP = 3'd1,
    ST_RD  = 3'd2,
    ST_WR  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_n;
  logic [DMEM_AW-1:0] a_q;
  logic [31:0]        d_q;
  logic [2:0]         op_q;
  logic               we_q;
  logic               err_q;
  logic [31:0]        rdata_q;
  logic               ld_wait_q;

  logic [31:0] off;
  logic        range_err;
  logic        op_err;
  logic        mis_err;
  logic        acc_err;
  logic        accept;

  assign off       = bus.req_addr - DMEM_BASE;
  assign range_err = |off[31:DMEM_AW];
  assign op_err    = (bus.req_memop[1:0] == 2'b11);

`ifdef DMEM_LSU_ALIGN_CHECK_EN
  assign mis_err = ((bus.req_memop[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_memop[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
  assign mis_err = 1'b0;
`endif

  assign acc_err = range_err | op_err | mis_err;
  assign accept  = bus.req_valid & bus.req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // The first LD_CAP cycle lets dmem_ctrl register q; the second captures it.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (acc_err)          state_n = RESP;
          else if (bus.req_we)  state_n = ST_RD;
          else                  state_n = LD_CAP;
        end
      end
      LD_CAP:  if (!ld_wait_q) state_n = RESP;
      ST_RD:   state_n = ST_WR;
      ST_WR:   state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.mem_we    = (state_q == ST_RD) || (state_q == ST_WR);
    bus.rsp_err   = err_q;
    bus.rsp_rdata = 32'h0;
    if ((state_q == RESP) && !we_q && !err_q) bus.rsp_rdata = rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      d_q       <= 32'h0;
      op_q      <= 3'b000;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
      ld_wait_q <= 1'b0;
    end else if (accept) begin
      a_q       <= off[DMEM_AW-1:0];
      d_q       <= bus.req_wdata;
      op_q      <= bus.req_memop;
      we_q      <= bus.req_we;
      err_q     <= acc_err;
      ld_wait_q <= 1'b1;
    end else if (state_q == LD_CAP) begin
      ld_wait_q <= 1'b0;
      if (!ld_wait_q) rdata_q <= bus.mem_dataout;
    end
  end

  assign bus.mem_addr   = a_q;
  assign bus.mem_datain = d_q;
  assign bus.mem_memop  = op_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural dmem_ctrl stand-in and a
// transaction-level reference model checked every cycle.
module tb_dmem_lsu;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          AW   = 18;

  typedef struct {
    int          acc;
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  dmem_lsu_if #(.DMEM_AW(AW)) bus ();

  dmem_lsu #(.DMEM_BASE(BASE), .DMEM_AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_chk;
  int n_fail;
  int cyc;
  int rsp_count;
  int last_lat;
  logic [31:0] last_rdata;
  logic        last_err;
  txn_t exp_q[$];
  int   acc_log[$];

  logic [31:0] dm  [0:63];
  logic [31:0] mdl [0:63];
  logic [31:0] q_word;
  logic        wr_phase;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [2:0] op);
    logic [31:0] r;
    int sz;
    r  = 32'h0;
    sz = 1 << op[1:0];
    for (int k = 0; k < sz; k++)
      if (int'(off) + k < 4) r[8*k +: 8] = w[8*(int'(off) + k) +: 8];
    if (!op[2] && sz < 4 && r[8*sz-1])
      for (int b = 8*sz; b < 32; b++) r[b] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] off, input logic [2:0] op);
    logic [31:0] r;
    int sz;
    r  = w;
    sz = 1 << op[1:0];
    for (int k = 0; k < sz; k++)
      if (int'(off) + k < 4) r[8*(int'(off) + k) +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic model_err(input logic [31:0] addr, input logic [2:0] op);
    logic [31:0] o;
    logic e;
    o = addr - BASE;
    e = (o >= (32'h1 << AW)) || (op[1:0] == 2'b11);
`ifdef DMEM_LSU_ALIGN_CHECK_EN
    if ((op[1:0] == 2'b01) && addr[0]) e = 1'b1;
    if ((op[1:0] == 2'b10) && (addr[1:0] != 2'b00)) e = 1'b1;
`endif
    return e;
  endfunction

  // dmem_ctrl stand-in: registered read word, first we cycle captures, second writes.
  always @(posedge clk) begin
    q_word <= dm[bus.mem_addr[7:2]];
    if (bus.mem_we) begin
      if (wr_phase)
        dm[bus.mem_addr[7:2]] <= merge(q_word, bus.mem_datain, bus.mem_addr[1:0], bus.mem_memop);
      wr_phase <= ~wr_phase;
    end else begin
      wr_phase <= 1'b0;
    end
  end

  assign bus.mem_dataout = extract(q_word, bus.mem_addr[1:0], bus.mem_memop);

  // Accept monitor.
  always @(posedge clk) begin
    txn_t t;
    cyc++;
    if (!rst && bus.req_valid && bus.req_ready) begin
      t.acc   = cyc;
      t.we    = bus.req_we;
      t.op    = bus.req_memop;
      t.addr  = bus.req_addr;
      t.wdata = bus.req_wdata;
      exp_q.push_back(t);
      acc_log.push_back(cyc);
    end
  end

  // Per-cycle compare against the transaction model.
  always @(negedge clk) begin
    txn_t        t;
    logic        e;
    logic        we_exp;
    logic [31:0] o;
    logic [31:0] rd;
    int          due;
    if (rst) begin
      exp_q.delete();
    end else begin
      we_exp = 1'b0;
      if (exp_q.size() != 0) begin
        t = exp_q[0];
        if (t.we && !model_err(t.addr, t.op) && (cyc == t.acc || cyc == t.acc + 1))
          we_exp = 1'b1;
      end
      chk("req_ready", {31'h0, bus.req_ready}, {31'h0, exp_q.size() == 0});
      chk("mem_we", {31'h0, bus.mem_we}, {31'h0, we_exp});
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", {31'h0, bus.rsp_valid}, 32'h0);
        end else begin
          t  = exp_q.pop_front();
          e  = model_err(t.addr, t.op);
          o  = t.addr - BASE;
          due = e ? t.acc : t.acc + 2;
          rd = 32'h0;
          if (!e && !t.we) rd = extract(mdl[o[7:2]], o[1:0], t.op);
          if (!e && t.we)  mdl[o[7:2]] = merge(mdl[o[7:2]], t.wdata, o[1:0], t.op);
          chk("rsp_cycle", cyc, due);
          chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e});
          chk("rsp_rdata", bus.rsp_rdata, rd);
          last_rdata = bus.rsp_rdata;
          last_err   = bus.rsp_err;
          last_lat   = cyc - t.acc;
          rsp_count++;
        end
      end else if (exp_q.size() != 0) begin
        t = exp_q[0];
        due = model_err(t.addr, t.op) ? t.acc : t.acc + 2;
        if (cyc > due) begin
          chk("missed_rsp", 32'h0, 32'h1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic we, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wd, input bit hold);
    int n;
    @(negedge clk);
    bus.req_we    = we;
    bus.req_memop = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("send_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("rsp_timeout", 32'h0, 32'h1);
    @(negedge clk);
  endtask

  task automatic xfer(input logic we, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wd);
    send(we, op, addr, wd, 1'b0);
    wait_done();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; rsp_count = 0; last_lat = 0;
    last_rdata = 32'h0; last_err = 1'b0;
    q_word = 32'h0; wr_phase = 1'b0;
    for (int i = 0; i < 64; i++) begin
      dm[i]  = 32'hA5A5_0000 | i;
      mdl[i] = 32'hA5A5_0000 | i;
    end
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_memop = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_ready",  {31'h0, bus.req_ready}, 32'h1);
    chk("reset_rsp_v",  {31'h0, bus.rsp_valid}, 32'h0);
    chk("reset_rsp_e",  {31'h0, bus.rsp_err}, 32'h0);
    chk("reset_rdata",  bus.rsp_rdata, 32'h0);
    chk("reset_we",     {31'h0, bus.mem_we}, 32'h0);
    chk("reset_addr",   {14'h0, bus.mem_addr}, 32'h0);
    chk("reset_datain", bus.mem_datain, 32'h0);
    chk("reset_memop",  {29'h0, bus.mem_memop}, 32'h0);
    chk("reset_state",  {29'h0, dbg_state}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;

    xfer(1'b1, 3'b010, 32'h40, 32'hDEADBEEF);
    chk("st_word_err", {31'h0, last_err}, 32'h0);
    chk("st_word_lat", last_lat, 2);
    xfer(1'b0, 3'b010, 32'h40, 32'h0);
    chk("ld_word", last_rdata, 32'hDEADBEEF);
    chk("ld_word_lat", last_lat, 2);

    xfer(1'b1, 3'b000, 32'h41, 32'h0000_0080);
    xfer(1'b0, 3'b000, 32'h41, 32'h0);
    chk("ld_sbyte", last_rdata, 32'hFFFFFF80);
    xfer(1'b0, 3'b100, 32'h41, 32'h0);
    chk("ld_ubyte", last_rdata, 32'h00000080);
    xfer(1'b0, 3'b010, 32'h40, 32'h0);
    chk("ld_word_merged", last_rdata, 32'hDEAD80EF);

    xfer(1'b0, 3'b010, BASE + 32'h0004_0000, 32'h0);
    chk("range_err", {31'h0, last_err}, 32'h1);
    chk("range_err_lat", last_lat, 0);
    xfer(1'b1, 3'b010, BASE + 32'h0004_0000, 32'h1111_1111);
    chk("range_st_err", {31'h0, last_err}, 32'h1);
    xfer(1'b0, 3'b011, 32'h40, 32'h0);
    chk("illegal_op_err", {31'h0, last_err}, 32'h1);

    xfer(1'b1, 3'b001, 32'h43, 32'h0000_1234);
`ifdef DMEM_LSU_ALIGN_CHECK_EN
    chk("mis_half_err", {31'h0, last_err}, 32'h1);
    xfer(1'b0, 3'b010, 32'h40, 32'h0);
    chk("mis_half_word", last_rdata, 32'hDEAD80EF);
`else
    chk("mis_half_err", {31'h0, last_err}, 32'h0);
    xfer(1'b0, 3'b010, 32'h40, 32'h0);
    chk("mis_half_word", last_rdata, 32'h34AD80EF);
`endif

    send(1'b1, 3'b010, 32'h80, 32'h12345678, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("abort_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("abort_rsp_v", {31'h0, bus.rsp_valid}, 32'h0);
    chk("abort_we",    {31'h0, bus.mem_we}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_mem", dm[32], 32'hA5A50020);
    xfer(1'b0, 3'b010, 32'h80, 32'h0);
    chk("abort_ld", last_rdata, 32'hA5A50020);

    acc_log.delete();
    rsp_count = 0;
    send(1'b0, 3'b010, 32'h40, 32'h0, 1'b1);
    send(1'b0, 3'b000, 32'h41, 32'h0, 1'b1);
    send(1'b0, 3'b101, 32'h42, 32'h0, 1'b0);
    wait_done();
    chk("b2b_rsp_count", rsp_count, 3);
    chk("b2b_acc_count", acc_log.size(), 3);
    if (acc_log.size() == 3) begin
      chk("b2b_gap1", acc_log[1] - acc_log[0], 4);
      chk("b2b_gap2", acc_log[2] - acc_log[1], 4);
    end
`ifdef DMEM_LSU_ALIGN_CHECK_EN
    chk("b2b_last", last_rdata, 32'h0000DEAD);
`else
    chk("b2b_last", last_rdata, 32'h000034AD);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
